matmul_10x10_seq_ctrl: RTL and testbench
========================================

Name: matmul_10x10_seq_ctrl

Overview:
Sequencing controller for the 10x10 matrix-matrix multiply. It replaces the fully parallel array with one shared, pipelined 8x8 multiplier plus an accumulator, and steps that resource through all N^3 products. Start/busy/done handshake on the control side. The flattened operand and result buses use the same layout as the existing top-level, so the block drops in where the parallel top sits.

Parameters:
N, 10, matrix dimension (square N x N)
DW, 8, operand element width (unsigned)
RW, 16, result element width (unsigned, truncated)
MAC_LAT, 2, multiplier pipeline stages (>=1) between issue and accumulate

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a multiply; accepted only in IDLE
abort  input  1  synchronous cancel of a running multiply
matrix_a  input  N*N*DW  flattened A, element [i][k] at bits i*N*DW + k*DW +: DW
matrix_b  input  N*N*DW  flattened B, element [k][j] at bits k*N*DW + j*DW +: DW
busy  output  1  high from the cycle after accept until done/abort
done  output  1  one-cycle pulse when all N*N results are written
result_valid  output  1  result holds a complete product
result  output  N*N*RW  flattened C, element [i][j] at bits i*N*RW + j*RW +: RW

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, result_valid=0, result=0. Counters, pipeline valids and accumulator are cleared. Reset asserted mid-run also drops busy immediately, and no done is produced.
- FSM: IDLE -> RUN (start=1 at an edge while IDLE) -> DRAIN (last product issued) -> DONE (last result written) -> IDLE (next edge). abort=1 in RUN or DRAIN -> IDLE at the next edge.
- Accept edge: matrix_a and matrix_b are captured into internal operand registers. Inputs may change freely afterwards. result_valid clears at the same edge. start in any state other than IDLE is ignored, with no side effects.
- Issue order in RUN: i outer, j middle, k inner, all counting 0..N-1. Exactly one product a[i][k]*b[k][j] is issued per cycle with no bubbles, so issue occupies N^3 consecutive cycles starting the cycle after accept.
- Each issue carries tags first=(k==0), last=(k==N-1), and the (i,j) index through the MAC_LAT stages.
- Accumulator is 2*DW+ceil(log2 N) bits wide (20 at defaults), so no internal overflow. On the first tag it loads the product; otherwise it adds the product.
- On the last tag, result[i][j] <= (accumulated sum) mod 2^RW, in the same edge. Elements not yet rewritten keep their previous values.
- Latency: done is high in the cycle following edge number N^3 + MAC_LAT + 1, counting the accept edge as 0 (1003 at defaults). result_valid is set at the same edge as done and stays set until the next accept. busy falls at the same edge done rises.
- abort: in-flight products are discarded (pipeline valids cleared). No done pulse. result_valid stays 0. result elements already written keep their new values. abort in IDLE or DONE has no effect.
- start and abort asserted together in IDLE: start is accepted. In RUN: abort wins.
- start held high continuously: a new multiply is accepted in the IDLE cycle after each DONE (back-to-back runs, with one IDLE cycle between them).

Test Plan:
- Row/column pattern: A row i all (i+1), B column j all (j+1), pulse start -> done at edge 1003; result[0][0]=10, result[2][4]=150, result[9][9]=1000; result_valid=1; busy falls with done.
- Identity: A=I, B[k][j]=k*10+j -> result equals B zero-extended to 16 bits. Operands are changed after accept -> result unaffected.
- Overflow: all elements 255 -> every result element = 650250 mod 65536 = 60426.
- start pulsed at cycles 5 and 500 during a run -> ignored; exactly one done, at edge 1003 after the first accept.
- abort at cycle 300 of RUN -> IDLE next edge, busy=0, no done, result_valid=0. A following start with the pattern from scenario 1 -> correct full result.
- reset driven low at cycle 400 of RUN (asynchronous, mid-cycle) -> busy, result_valid and all of result read 0 immediately. After release, a new run completes correctly.

Source files
------------

// File: rtl/matmul_10x10_seq_ctrl.sv
// Sequential N x N matrix multiply: one pipelined DW x DW multiplier and one
// accumulator stepped through all N^3 products, with a start/busy/done handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; operands are captured on accept
// S_RUN   | issuing one product per cycle, i outer / j middle / k inner
// S_DRAIN | last product issued, waiting for the pipeline to empty
// S_DONE  | done pulse cycle; result_valid set, returns to S_IDLE
module matmul_10x10_seq_ctrl #(
    parameter int N       = 10,
    parameter int DW      = 8,
    parameter int RW      = 16,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [N*N*DW-1:0] matrix_a,
    input  logic [N*N*DW-1:0] matrix_b,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic [N*N*RW-1:0] result
);
    localparam int IW     = (N > 1) ? $clog2(N) : 1;
    localparam int PW     = 2 * DW;
    localparam int AW     = 2 * DW + $clog2(N);
    localparam int PIPE_W = MAC_LAT * PW;
    localparam int TAG_W  = MAC_LAT * IW;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state;

    // Packed [row][col][bit] matches the flattened bus layout exactly.
    logic [N-1:0][N-1:0][DW-1:0] a_reg, b_reg;
    logic [N-1:0][N-1:0][RW-1:0] res_q;
    logic [IW-1:0]               ci, cj, ck;

    logic                       issue, flush;
    logic [PW-1:0]              prod_new;
    logic [MAC_LAT-1:0]         vld_q, first_q, last_q;
    logic [MAC_LAT-1:0][PW-1:0] prod_q;
    logic [MAC_LAT-1:0][IW-1:0] ti_q, tj_q;
    logic [AW-1:0]              acc, sum;

    assign issue    = (state == S_RUN) && !abort;
    assign flush    = abort && ((state == S_RUN) || (state == S_DRAIN));
    assign prod_new = PW'(a_reg[ci][ck]) * PW'(b_reg[ck][cj]);
    assign sum      = first_q[MAC_LAT-1] ? AW'(prod_q[MAC_LAT-1])
                                         : acc + AW'(prod_q[MAC_LAT-1]);
    assign result   = res_q;

    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            a_reg <= matrix_a;
            b_reg <= matrix_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            ci           <= '0;
            cj           <= '0;
            ck           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_RUN;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        ci           <= '0;
                        cj           <= '0;
                        ck           <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (ck == LAST) begin
                        ck <= '0;
                        if (cj == LAST) begin
                            cj <= '0;
                            if (ci == LAST) state <= S_DRAIN;
                            else            ci    <= ci + IW'(1);
                        end else begin
                            cj <= cj + IW'(1);
                        end
                    end else begin
                        ck <= ck + IW'(1);
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (vld_q == '0) begin
                        state        <= S_DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        result_valid <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage 0 is the newest entry; the cast drops the oldest stage on each shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            prod_q  <= '0;
            ti_q    <= '0;
            tj_q    <= '0;
            acc     <= '0;
            res_q   <= '0;
        end else begin
            vld_q   <= flush ? '0 : MAC_LAT'({vld_q, issue});
            first_q <= MAC_LAT'({first_q, (ck == '0)});
            last_q  <= MAC_LAT'({last_q, (ck == LAST)});
            prod_q  <= PIPE_W'({prod_q, prod_new});
            ti_q    <= TAG_W'({ti_q, ci});
            tj_q    <= TAG_W'({tj_q, cj});
            if (vld_q[MAC_LAT-1] && !flush) begin
                acc <= sum;
                if (last_q[MAC_LAT-1])
                    res_q[ti_q[MAC_LAT-1]][tj_q[MAC_LAT-1]] <= sum[RW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_matmul_10x10_seq_ctrl.sv
// Directed bench for matmul_10x10_seq_ctrl: fixed operand patterns with
// hand-computed products, latency, start/abort/reset interaction.
module tb_matmul_10x10_seq_ctrl;
    localparam int N = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [N-1:0][N-1:0][7:0]  ma, mb;
    logic [N-1:0][N-1:0][15:0] res;
    logic busy, done, result_valid;

    int errors = 0;
    int checks = 0;
    int d0, d1, nd;

    always #5 clk = ~clk;

    matmul_10x10_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .matrix_a     (ma),
        .matrix_b     (mb),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .result       (res)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_rowcol();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[4'(r)][4'(c)] = 8'(r + 1);
                mb[4'(r)][4'(c)] = 8'(c + 1);
            end
    endtask

    task automatic load_identity();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[4'(r)][4'(c)] = (r == c) ? 8'd1 : 8'd0;
                mb[4'(r)][4'(c)] = 8'(r * 10 + c);
            end
    endtask

    task automatic load_all255();
        ma = '1;
        mb = '1;
    endtask

    // kind 0: row/col pattern, 1: identity x B, 2: all 255
    task automatic sweep(input string tag, input int kind);
        int bad;
        logic [15:0] e;
        bad = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                case (kind)
                    0:       e = 16'(10 * (r + 1) * (c + 1));
                    1:       e = 16'(r * 10 + c);
                    default: e = 16'd60426;
                endcase
                if (res[4'(r)][4'(c)] !== e) bad++;
            end
        chk(tag, 32'(bad), 32'd0);
    endtask

    // n counts edges after the accept edge (edge 0); checks run at negedges.
    task automatic run_mm(input int max_n, input int pulse_a, input int pulse_b,
                          input int abort_at, input int rst_at, input bit hold,
                          input bit scramble, input bit abort_on_accept,
                          output int first_done, output int second_done, output int ndone);
        int   n;
        logic pb;
        first_done  = -1;
        second_done = -1;
        ndone       = 0;
        @(negedge clk);
        start = 1'b1;
        abort = abort_on_accept;
        @(negedge clk);
        abort = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("rv_clear_on_accept", 32'(result_valid), 32'd0);
        pb = busy;
        n  = 0;
        while (n < max_n) begin
            start = hold ? 1'b1 : ((n == pulse_a) || (n == pulse_b));
            abort = (n == abort_at);
            if (scramble && n == 0) begin
                ma = '1;
                mb = '0;
            end
            if (n == rst_at) begin
                #2 reset = 1'b0;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_rv", 32'(result_valid), 32'd0);
                chk("rst_result_zero", 32'(|res), 32'd0);
            end
            @(negedge clk);
            n++;
            if (rst_at >= 0 && n == rst_at + 1) reset = 1'b1;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = n;
                else if (second_done < 0) second_done = n;
                chk("busy_low_at_done", 32'(busy), 32'd0);
                chk("busy_high_before_done", 32'(pb), 32'd1);
            end
            if (abort_at >= 0 && n == abort_at + 1) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_rv", 32'(result_valid), 32'd0);
            end
            pb = busy;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ma = '0;
        mb = '0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rv", 32'(result_valid), 32'd0);
        chk("reset_result", 32'(|res), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Row/column pattern, with stray start pulses during the run
        load_rowcol();
        run_mm(1010, 5, 500, -1, -1, 1'b0, 1'b0, 1'b0, d0, d1, nd);
        chk("rc_done_edge", 32'(d0), 32'd1003);
        chk("rc_ndone", 32'(nd), 32'd1);
        chk("rc_rv", 32'(result_valid), 32'd1);
        chk("rc_c00", 32'(res[0][0]), 32'd10);
        chk("rc_c24", 32'(res[2][4]), 32'd150);
        chk("rc_c99", 32'(res[9][9]), 32'd1000);
        sweep("rc_all", 0);

        // Identity; start with abort in IDLE, operands scrambled after accept
        load_identity();
        run_mm(1010, -1, -1, -1, -1, 1'b0, 1'b1, 1'b1, d0, d1, nd);
        chk("id_done_edge", 32'(d0), 32'd1003);
        chk("id_c37", 32'(res[3][7]), 32'd37);
        chk("id_c99", 32'(res[9][9]), 32'd99);
        sweep("id_all", 1);

        // Truncation of a 20-bit sum to 16 bits
        load_all255();
        run_mm(1010, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0, d0, d1, nd);
        chk("ovf_done_edge", 32'(d0), 32'd1003);
        chk("ovf_c52", 32'(res[5][2]), 32'd60426);
        sweep("ovf_all", 2);

        // Abort at cycle 300: elements up to [2][8] rewritten, [2][9] onward kept
        load_rowcol();
        run_mm(310, -1, -1, 300, -1, 1'b0, 1'b0, 1'b0, d0, d1, nd);
        chk("abort_ndone", 32'(nd), 32'd0);
        chk("abort_rv_end", 32'(result_valid), 32'd0);
        chk("abort_c00", 32'(res[0][0]), 32'd10);
        chk("abort_c28", 32'(res[2][8]), 32'd270);
        chk("abort_c29", 32'(res[2][9]), 32'd60426);
        chk("abort_c99", 32'(res[9][9]), 32'd60426);
        run_mm(1010, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0, d0, d1, nd);
        chk("post_abort_done_edge", 32'(d0), 32'd1003);
        sweep("post_abort_all", 0);

        // Asynchronous reset mid-run, then a clean run
        load_identity();
        run_mm(420, -1, -1, -1, 400, 1'b0, 1'b0, 1'b0, d0, d1, nd);
        chk("rst_ndone", 32'(nd), 32'd0);
        load_rowcol();
        run_mm(1010, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0, d0, d1, nd);
        chk("post_rst_done_edge", 32'(d0), 32'd1003);
        chk("post_rst_rv", 32'(result_valid), 32'd1);
        sweep("post_rst_all", 0);

        // start held high: back-to-back runs with one IDLE cycle between
        load_identity();
        run_mm(2009, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0, d0, d1, nd);
        chk("b2b_first_done", 32'(d0), 32'd1003);
        chk("b2b_second_done", 32'(d1), 32'd2008);
        chk("b2b_ndone", 32'(nd), 32'd2);
        sweep("b2b_all", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
